idma_stream_scheduler: RTL
==========================

// Module: idma_stream_scheduler
// PURPOSE
// - Sits between the per-stream register front-ends and the single iDMA back-end (or ND mid-end) request port.
// - Arbitrates round-robin over NumStreams request channels; per-stream outstanding cap enforced; per-stream transfer IDs.
// - Registers the winning request toward the back-end; reports next_id/done_id/busy per stream to the front-end status regs.
// PARAMETERS
// - NumStreams      1   number of request streams (1..16)
// - IdCounterWidth  32  transfer-ID width; IDs wrap modulo 2**IdCounterWidth
// - MaxOutstanding  4   max accepted-but-not-completed transfers per stream (>=1)
// - dma_req_t       logic  request payload type (1D or ND burst request), passed through unmodified
// - StreamWidth     idx_width(NumStreams)  dependent; stream index width
// PORTS
// - clk_i         in   1                          clock
// - rst_i         in   1                          reset, asynchronous, active-high
// - req_i         in   NumStreams x dma_req_t     per-stream request payload
// - req_valid_i   in   NumStreams                 per-stream request valid
// - req_ready_o   out  NumStreams                 per-stream request ready (grant)
// - dma_req_o     out  dma_req_t                  registered request to back-end
// - dma_valid_o   out  1                          back-end request valid
// - dma_ready_i   in   1                          back-end request ready
// - dma_stream_o  out  StreamWidth                stream index of dma_req_o
// - dma_id_o      out  IdCounterWidth             transfer ID of dma_req_o
// - rsp_valid_i   in   1                          back-end completion strobe (one transfer done)
// - rsp_stream_i  in   StreamWidth                stream of completed transfer
// - next_id_o     out  NumStreams x IdCounterWidth ID the next accepted request of stream s receives
// - done_id_o     out  NumStreams x IdCounterWidth ID of the last completed transfer of stream s
// - busy_o        out  NumStreams                 stream s has >=1 outstanding transfer
// BEHAVIOUR
// - Reset (async, any cycle incl. mid-transfer): dma_valid_o=0, dma_req_o/dma_stream_o/dma_id_o='0, next_id_o[s]=1,
//   done_id_o[s]=0, busy_o=0, outstanding[s]=0, RR pointer=0; in-flight request dropped, not replayed.
// - Eligible(s) = req_valid_i[s] && outstanding[s] < MaxOutstanding.
// - Output slot free = !dma_valid_o || dma_ready_i (drain and refill in same cycle allowed).
// - Grant: when slot free, lowest eligible index >= RR pointer wins (wrapping); req_ready_o[winner]=1, all others 0.
//   No grant when slot occupied/stalled; req_ready_o all 0. req_ready_o is combinational from req_valid_i (AXI rule:
//   valid must not depend on ready); a requester must hold req_i stable while valid && !ready.
// - On grant of s: dma_req_o<=req_i[s], dma_stream_o<=s, dma_id_o<=next_id[s], dma_valid_o<=1; next_id[s]+=1 (wrap);
//   outstanding[s]+=1; RR pointer <= s+1 (mod NumStreams). Latency req handshake -> dma_valid_o: 1 cycle.
// - dma_valid_o held with stable payload until dma_ready_i; drained with no new grant -> dma_valid_o<=0.
// - Outstanding counted from acceptance at req side (not back-end handshake), so a request in the output slot holds a credit.
// - Completion: rsp_valid_i with stream r -> done_id[r]+=1 (wrap), outstanding[r]-=1. Back-end completes in order per stream,
//   so done_id equals the ID of the transfer just finished.
// - Same-cycle grant and completion on same stream: outstanding unchanged, both ID counters advance.
// - Completion with outstanding[r]==0 or rsp_stream_i>=NumStreams: ignored (no counter change); flagged by assertion.
// - Stream at cap: excluded from arbitration; other streams proceed (no head-of-line blocking across streams).
// - busy_o[s] = outstanding[s]!=0, registered-state derived (no combinational path from inputs).
// - ID wrap: next_id 2**W-1 -> 0 -> 1...; ID 0 is valid after wrap. Counters width IdCounterWidth;
//   outstanding width $clog2(MaxOutstanding+1).
// - NumStreams==1: arbiter degenerates to pass-through gate; dma_stream_o constant 0.
// TESTING
// - Reset release, stream0 single request, dma_ready_i=1 -> dma_valid_o 1 cycle later, dma_id_o=1; rsp -> done_id_o[0]=1, busy_o[0]=0.
// - NumStreams=4, all valid, ready tied 1 -> grants 0,1,2,3,0,... one per cycle, dma_id_o per stream 1,2,3...
// - MaxOutstanding=4, stream1 valid, no completions -> exactly 4 grants, req_ready_o[1]=0 after; one rsp -> 5th grant next cycle.
// - dma_ready_i=0 for 10 cycles with pending output -> dma_req_o/id/stream stable, no req_ready_o asserted; release -> continues.
// - next_id preset near 2**W-1 (W=4): grants yield IDs 14,15,0,1; done_id follows identically on completions.
// - rst_i pulse while dma_valid_o=1 and outstanding=3 -> all outputs return to reset values asynchronously; next grant gets ID 1.

Source files
------------

// File: rtl/idma_stream_scheduler.sv
// Round-robin scheduler feeding one iDMA back-end request port from several
// request streams. Keeps a per-stream credit count of accepted-but-not-completed
// transfers and per-stream next/done transfer ID counters.
module idma_stream_scheduler #(
    parameter int unsigned NumStreams     = 1,
    parameter int unsigned IdCounterWidth = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         dma_req_t      = logic,
    parameter int unsigned StreamWidth    = (NumStreams > 1) ? $clog2(NumStreams) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  dma_req_t [NumStreams-1:0]                  req_i,
    input  logic     [NumStreams-1:0]                  req_valid_i,
    output logic     [NumStreams-1:0]                  req_ready_o,
    output dma_req_t                                   dma_req_o,
    output logic                                       dma_valid_o,
    input  logic                                       dma_ready_i,
    output logic     [StreamWidth-1:0]                 dma_stream_o,
    output logic     [IdCounterWidth-1:0]              dma_id_o,
    input  logic                                       rsp_valid_i,
    input  logic     [StreamWidth-1:0]                 rsp_stream_i,
    output logic     [NumStreams-1:0][IdCounterWidth-1:0] next_id_o,
    output logic     [NumStreams-1:0][IdCounterWidth-1:0] done_id_o,
    output logic     [NumStreams-1:0]                  busy_o
);

    localparam int unsigned OutWidth = $clog2(MaxOutstanding + 1);
    localparam logic [OutWidth-1:0] MaxOut = OutWidth'(MaxOutstanding);

    // Output slot toward the back-end
    dma_req_t                  r_dma_req;
    logic                      r_dma_valid;
    logic [StreamWidth-1:0]    r_dma_stream;
    logic [IdCounterWidth-1:0] r_dma_id;

    // Per-stream bookkeeping
    logic [IdCounterWidth-1:0] r_next_id     [NumStreams];
    logic [IdCounterWidth-1:0] r_done_id     [NumStreams];
    logic [OutWidth-1:0]       r_outstanding [NumStreams];
    logic [StreamWidth-1:0]    r_rr_ptr;

    logic                      w_slot_free;
    logic [NumStreams-1:0]     w_eligible;
    logic                      w_grant;
    logic [StreamWidth-1:0]    w_winner;
    logic [NumStreams-1:0]     w_inc;
    logic [NumStreams-1:0]     w_dec;

    // The slot can be refilled in the same cycle it drains
    assign w_slot_free = !r_dma_valid || dma_ready_i;

    // Per-stream eligibility, grant one-hot and completion decode
    always_comb begin
        w_eligible = '0;
        w_dec      = '0;
        for (int unsigned s = 0; s < NumStreams; s++) begin
            w_eligible[s] = req_valid_i[s] && (r_outstanding[s] < MaxOut);
            // Out-of-range stream indices match no stream and are dropped
            w_dec[s] = rsp_valid_i && (rsp_stream_i == StreamWidth'(s))
                       && (r_outstanding[s] != '0);
        end
    end

    // Round-robin search starting at the pointer, wrapping past the last stream
    always_comb begin
        w_grant  = 1'b0;
        w_winner = '0;
        for (int unsigned k = 0; k < NumStreams; k++) begin
            int unsigned idx;
            idx = 32'(r_rr_ptr) + k;
            if (idx >= NumStreams) begin
                idx = idx - NumStreams;
            end
            if (!w_grant && w_slot_free && w_eligible[idx]) begin
                w_grant  = 1'b1;
                w_winner = StreamWidth'(idx);
            end
        end
    end

    // Grant strobes back to the requesters and status outputs
    always_comb begin
        req_ready_o = '0;
        w_inc       = '0;
        busy_o      = '0;
        next_id_o   = '0;
        done_id_o   = '0;
        for (int unsigned s = 0; s < NumStreams; s++) begin
            req_ready_o[s] = w_grant && (w_winner == StreamWidth'(s));
            w_inc[s]       = req_ready_o[s];
            busy_o[s]      = (r_outstanding[s] != '0);
            next_id_o[s]   = r_next_id[s];
            done_id_o[s]   = r_done_id[s];
        end
    end

    assign dma_req_o    = r_dma_req;
    assign dma_valid_o  = r_dma_valid;
    assign dma_stream_o = r_dma_stream;
    assign dma_id_o     = r_dma_id;

    // Output slot and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dma_req    <= '0;
            r_dma_valid  <= 1'b0;
            r_dma_stream <= '0;
            r_dma_id     <= '0;
            r_rr_ptr     <= '0;
        end else if (w_grant) begin
            r_dma_req    <= req_i[w_winner];
            r_dma_valid  <= 1'b1;
            r_dma_stream <= w_winner;
            r_dma_id     <= r_next_id[w_winner];
            r_rr_ptr     <= (32'(w_winner) == NumStreams - 1) ? '0 : w_winner + 1'b1;
        end else if (dma_ready_i) begin
            r_dma_valid  <= 1'b0;
        end
    end

    // Per-stream ID counters and credits; a request holds its credit from acceptance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < NumStreams; s++) begin
                r_next_id[s]     <= IdCounterWidth'(1);
                r_done_id[s]     <= '0;
                r_outstanding[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NumStreams; s++) begin
                if (w_inc[s]) begin
                    r_next_id[s] <= r_next_id[s] + 1'b1;
                end
                if (w_dec[s]) begin
                    r_done_id[s] <= r_done_id[s] + 1'b1;
                end
                if (w_inc[s] && !w_dec[s]) begin
                    r_outstanding[s] <= r_outstanding[s] + 1'b1;
                end else if (!w_inc[s] && w_dec[s]) begin
                    r_outstanding[s] <= r_outstanding[s] - 1'b1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A completion must name a real stream that has something outstanding
    assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid_i |-> ((32'(rsp_stream_i) < NumStreams)
                         && (r_outstanding[rsp_stream_i] != '0)));
`endif

endmodule
